// File: rtl/fetch_mem_if_ooo.sv
// Fetch/memory interface: issues tagged instruction reads, collects out-of-order
// answers in a small reorder buffer and hands instructions to issue in program order.

package fetch_mem_if_ooo_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned MEM_TAG_W = 4;

  typedef logic [ILEN-1:0] instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED   = 4'd0,
    EXC_INSTR_ACCESS_FAULT = 4'd1,
    EXC_ILLEGAL_INSTR      = 4'd2,
    EXC_LOAD_ACCESS_FAULT  = 4'd5
  } except_code_t;

  typedef enum logic [1:0] {
    MEM_ACC_INSTR = 2'd0,
    MEM_ACC_LOAD  = 2'd1,
    MEM_ACC_STORE = 2'd2
  } mem_acc_type_t;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } ls_size_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0] tag;
    mem_acc_type_t        acc_type;
    ls_size_t             size;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      value;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0] tag;
    mem_acc_type_t        acc_type;
    logic [XLEN-1:0]      value;
    logic                 except_raised;
    except_code_t         except_code;
  } mem_ans_t;
endpackage

module fetch_mem_if_ooo
  import fetch_mem_if_ooo_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  prediction_t  fetch_pred_i,
  output logic         issue_valid_o,
  input  logic         issue_ready_i,
  output instr_t       issue_instr_o,
  output prediction_t  issue_pred_o,
  output logic         issue_except_raised_o,
  output except_code_t issue_except_code_o,
  output logic         mem_valid_o,
  input  logic         mem_ready_i,
  output mem_req_t     mem_req_o,
  input  logic         mem_valid_i,
  output logic         mem_ready_o,
  input  mem_ans_t     mem_ans_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic         valid;
    logic         done;
    prediction_t  pred;
    instr_t       instr;
    logic         exc;
    except_code_t code;
  } slot_t;

  slot_t            slots [MAX_OUTSTANDING];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] ans_tag;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_next;
  logic             drain;
  logic             full;
  logic             can_req;
  logic             req_fire;
  logic             ans_count;
  logic             ans_store;
  logic             pop;
  logic             unused_tag_bits;

  // out_cnt tracks every unanswered request, including ones orphaned by a flush.
  assign full         = (count == CNT_W'(MAX_OUTSTANDING));
  assign can_req      = !full && !drain && !flush_i && (out_cnt < CNT_W'(MAX_OUTSTANDING));
  assign req_fire     = fetch_valid_i && mem_ready_i && can_req;
  assign ans_count    = mem_valid_i && (mem_ans_i.acc_type == MEM_ACC_INSTR);
  assign ans_tag      = mem_ans_i.tag[TAG_W-1:0];
  assign ans_store    = ans_count && !drain && !flush_i &&
                        slots[ans_tag].valid && !slots[ans_tag].done;
  assign out_cnt_next = out_cnt + CNT_W'(req_fire) - CNT_W'(ans_count);
  assign pop          = issue_valid_o && issue_ready_i;

  assign unused_tag_bits = ^(mem_ans_i.tag >> TAG_W);

  assign fetch_ready_o = mem_ready_i && can_req;
  assign mem_valid_o   = fetch_valid_i && can_req;
  assign mem_ready_o   = 1'b1;

  always_comb begin
    mem_req_o          = '0;
    mem_req_o.tag      = MEM_TAG_W'(tail);
    mem_req_o.acc_type = MEM_ACC_INSTR;
    mem_req_o.size     = LS_WORD;
    mem_req_o.addr     = fetch_pred_i.pc;
    mem_req_o.value    = '0;
  end

  assign issue_valid_o         = slots[head].valid && slots[head].done;
  assign issue_instr_o         = slots[head].instr;
  assign issue_pred_o          = slots[head].pred;
  assign issue_except_raised_o = slots[head].exc;
  assign issue_except_code_o   = slots[head].code;

  // Store, pop and alloc never hit the same slot: a stored slot is not done,
  // a popped slot is done, and an allocated slot is invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        slots[i].valid <= 1'b0;
        slots[i].done  <= 1'b0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      out_cnt <= '0;
      drain   <= 1'b0;
    end else begin
      out_cnt <= out_cnt_next;
      if (flush_i) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
          slots[i].valid <= 1'b0;
          slots[i].done  <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
        drain <= (out_cnt_next != '0);
      end else begin
        if (drain && (out_cnt_next == '0)) begin
          drain <= 1'b0;
        end
        if (ans_store) begin
          slots[ans_tag].done  <= 1'b1;
          slots[ans_tag].instr <= mem_ans_i.value[ILEN-1:0];
          slots[ans_tag].exc   <= mem_ans_i.except_raised;
          slots[ans_tag].code  <= mem_ans_i.except_code;
        end
        if (pop) begin
          slots[head].valid <= 1'b0;
          slots[head].done  <= 1'b0;
          head              <= head + TAG_W'(1);
        end
        if (req_fire) begin
          slots[tail].valid <= 1'b1;
          slots[tail].done  <= 1'b0;
          slots[tail].pred  <= fetch_pred_i;
          tail              <= tail + TAG_W'(1);
        end
        count <= count + CNT_W'(req_fire) - CNT_W'(pop);
      end
    end
  end

  // An answer outside drain/flush must target a slot that is waiting for it.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (ans_count && !drain && !flush_i) |-> (slots[ans_tag].valid && !slots[ans_tag].done));

endmodule

// File: tb/tb_fetch_mem_if_ooo.sv
// Bench for fetch_mem_if_ooo: queue-based program-order model checked every cycle,
// plus directed scenarios with literal expectations on issue order and request tags.

module tb_fetch_mem_if_ooo;
  import fetch_mem_if_ooo_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  prediction_t  fetch_pred_i;
  logic         issue_valid_o;
  logic         issue_ready_i;
  instr_t       issue_instr_o;
  prediction_t  issue_pred_o;
  logic         issue_except_raised_o;
  except_code_t issue_except_code_o;
  logic         mem_valid_o;
  logic         mem_ready_i;
  mem_req_t     mem_req_o;
  logic         mem_valid_i;
  logic         mem_ready_o;
  mem_ans_t     mem_ans_i;

  fetch_mem_if_ooo #(.MAX_OUTSTANDING(N)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_ready_o         (fetch_ready_o),
    .fetch_pred_i          (fetch_pred_i),
    .issue_valid_o         (issue_valid_o),
    .issue_ready_i         (issue_ready_i),
    .issue_instr_o         (issue_instr_o),
    .issue_pred_o          (issue_pred_o),
    .issue_except_raised_o (issue_except_raised_o),
    .issue_except_code_o   (issue_except_code_o),
    .mem_valid_o           (mem_valid_o),
    .mem_ready_i           (mem_ready_i),
    .mem_req_o             (mem_req_o),
    .mem_valid_i           (mem_valid_i),
    .mem_ready_o           (mem_ready_o),
    .mem_ans_i             (mem_ans_i)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program-order model: one queue entry per accepted fetch, oldest first.
  typedef struct {
    int           tag;
    prediction_t  pred;
    bit           done;
    instr_t       instr;
    bit           exc;
    except_code_t code;
  } rob_entry_t;

  typedef struct {
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  code;
    int          c;
  } issue_rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  tag;
  } req_rec_t;

  rob_entry_t rob [$];
  int         next_tag;
  int         outstanding;
  bit         m_drain;
  issue_rec_t issue_log [$];
  req_rec_t   req_log [$];

  always @(negedge clk) begin : compare_proc
    bit         m_can, m_iv, m_mv, m_fr, counted, accept, popped;
    int         on;
    rob_entry_t e;
    issue_rec_t ir;
    req_rec_t   rr;
    if (rst_i) begin
      rob.delete();
      next_tag    = 0;
      outstanding = 0;
      m_drain     = 0;
    end else begin
      m_can = (rob.size() < N) && !m_drain && !flush_i && (outstanding < N);
      m_mv  = fetch_valid_i && m_can;
      m_fr  = mem_ready_i && m_can;
      m_iv  = 0;
      if (rob.size() > 0) m_iv = rob[0].done;

      checkOutput("issue_valid", 96'(issue_valid_o), 96'(m_iv));
      if (m_iv) begin
        checkOutput("issue_pred", 96'(issue_pred_o), 96'(rob[0].pred));
        checkOutput("issue_instr", 96'(issue_instr_o), 96'(rob[0].instr));
        checkOutput("issue_exc", 96'(issue_except_raised_o), 96'(rob[0].exc));
        checkOutput("issue_code", 96'(issue_except_code_o), 96'(rob[0].code));
      end
      checkOutput("fetch_ready", 96'(fetch_ready_o), 96'(m_fr));
      checkOutput("mem_valid", 96'(mem_valid_o), 96'(m_mv));
      checkOutput("mem_ready_o", 96'(mem_ready_o), 96'(1));
      if (m_mv) begin
        checkOutput("req_tag", 96'(mem_req_o.tag), 96'(next_tag));
        checkOutput("req_addr", 96'(mem_req_o.addr), 96'(fetch_pred_i.pc));
        checkOutput("req_acc", 96'(mem_req_o.acc_type), 96'(MEM_ACC_INSTR));
        checkOutput("req_size", 96'(mem_req_o.size), 96'(LS_WORD));
        checkOutput("req_value", 96'(mem_req_o.value), 96'(0));
      end

      if (issue_valid_o && issue_ready_i) begin
        ir.pc   = issue_pred_o.pc;
        ir.exc  = issue_except_raised_o;
        ir.code = issue_except_code_o;
        ir.c    = cyc;
        issue_log.push_back(ir);
      end
      if (mem_valid_o && mem_ready_i) begin
        rr.addr = mem_req_o.addr;
        rr.tag  = mem_req_o.tag;
        req_log.push_back(rr);
      end

      counted = mem_valid_i && (mem_ans_i.acc_type == MEM_ACC_INSTR);
      accept  = fetch_valid_i && mem_ready_i && m_can;
      popped  = m_iv && issue_ready_i;
      on      = outstanding + int'(accept) - int'(counted);
      if (flush_i) begin
        rob.delete();
        next_tag = 0;
        m_drain  = (on != 0);
      end else begin
        if (counted && !m_drain) begin
          for (int i = 0; i < rob.size(); i++) begin
            if (rob[i].tag == int'(mem_ans_i.tag) && !rob[i].done) begin
              rob[i].done  = 1;
              rob[i].instr = mem_ans_i.value;
              rob[i].exc   = mem_ans_i.except_raised;
              rob[i].code  = mem_ans_i.except_code;
              break;
            end
          end
        end
        if (popped) void'(rob.pop_front());
        if (accept) begin
          e.tag   = next_tag;
          e.pred  = fetch_pred_i;
          e.done  = 0;
          e.instr = '0;
          e.exc   = 0;
          e.code  = EXC_INSTR_MISALIGNED;
          rob.push_back(e);
          next_tag = (next_tag + 1) % N;
        end
        if (m_drain && on == 0) m_drain = 0;
      end
      outstanding = on;
    end
  end

  logic       snap_iv, snap_mv, snap_fr, snap_mr;
  logic [3:0] snap_tag;

  // Drives one cycle of inputs and snapshots the combinational outputs mid-cycle.
  task automatic applyStimulus(input bit fv, input logic [31:0] pc, input bit av, input int atag,
                               input mem_acc_type_t acc, input bit aexc, input except_code_t acode,
                               input bit rdy, input bit fl);
    fetch_valid_i           = fv;
    fetch_pred_i.pc         = pc;
    fetch_pred_i.taken      = pc[2];
    fetch_pred_i.target     = pc + 32'h100;
    mem_valid_i             = av;
    mem_ans_i.tag           = 4'(atag);
    mem_ans_i.acc_type      = acc;
    mem_ans_i.value         = {16'hC0DE, 8'(cyc), 8'(atag)};
    mem_ans_i.except_raised = aexc;
    mem_ans_i.except_code   = acode;
    issue_ready_i           = rdy;
    flush_i                 = fl;
    @(negedge clk);
    snap_iv  = issue_valid_o;
    snap_mv  = mem_valid_o;
    snap_fr  = fetch_ready_o;
    snap_mr  = mem_ready_o;
    snap_tag = mem_req_o.tag;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit fl = 0);
    applyStimulus(0, 32'h0, 0, 0, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, rdy, fl);
  endtask

  task automatic req(input logic [31:0] pc, input bit rdy);
    applyStimulus(1, pc, 0, 0, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, rdy, 0);
  endtask

  task automatic ans(input int tag, input bit rdy);
    applyStimulus(0, 32'h0, 1, tag, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, rdy, 0);
  endtask

  task automatic reqAns(input logic [31:0] pc, input int tag, input bit rdy);
    applyStimulus(1, pc, 1, tag, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, rdy, 0);
  endtask

  task automatic checkOrder(input string name, input logic [31:0] pcs [$]);
    checkOutput({name, "_count"}, 96'(issue_log.size()), 96'(pcs.size()));
    if (issue_log.size() == pcs.size()) begin
      for (int i = 0; i < pcs.size(); i++) begin
        checkOutput($sformatf("%s_pc%0d", name, i), 96'(issue_log[i].pc), 96'(pcs[i]));
      end
    end
  endtask

  task automatic clearLogs();
    issue_log.delete();
    req_log.delete();
  endtask

  initial begin : stim
    int t_ans;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pred_i  = '0;
    issue_ready_i = 1'b0;
    mem_ready_i   = 1'b1;
    mem_valid_i   = 1'b0;
    mem_ans_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    $display("[TB] reset state");
    idle(1);
    checkOutput("reset_issue_valid", 96'(snap_iv), 96'(0));
    checkOutput("reset_mem_valid", 96'(snap_mv), 96'(0));
    checkOutput("reset_fetch_ready", 96'(snap_fr), 96'(1));
    checkOutput("reset_mem_ready", 96'(snap_mr), 96'(1));
    mem_ready_i = 1'b0;
    req(32'h0, 1);
    checkOutput("noready_fetch_ready", 96'(snap_fr), 96'(0));
    checkOutput("noready_mem_valid", 96'(snap_mv), 96'(1));
    checkOutput("noready_no_req", 96'(req_log.size()), 96'(0));
    mem_ready_i = 1'b1;

    $display("[TB] in-order answers");
    clearLogs();
    req(32'h0, 1); req(32'h4, 1); req(32'h8, 1); req(32'hC, 1);
    t_ans = cyc;
    ans(0, 1); ans(1, 1); ans(2, 1); ans(3, 1);
    idle(1); idle(1);
    checkOrder("t1", '{32'h0, 32'h4, 32'h8, 32'hC});
    if (issue_log.size() == 4) begin
      checkOutput("t1_latency", 96'(issue_log[0].c), 96'(t_ans + 1));
      checkOutput("t1_no_bubbles", 96'(issue_log[3].c), 96'(t_ans + 4));
    end
    checkOutput("t1_req_count", 96'(req_log.size()), 96'(4));
    if (req_log.size() == 4) checkOutput("t1_last_tag", 96'(req_log[3].tag), 96'(3));

    $display("[TB] out-of-order answers");
    clearLogs();
    req(32'h0, 1); req(32'h4, 1); req(32'h8, 1); req(32'hC, 1);
    ans(2, 1);
    t_ans = cyc;
    ans(0, 1); ans(3, 1); ans(1, 1);
    repeat (4) idle(1);
    checkOrder("t2", '{32'h0, 32'h4, 32'h8, 32'hC});
    if (issue_log.size() == 4) checkOutput("t2_first_issue", 96'(issue_log[0].c), 96'(t_ans + 1));

    $display("[TB] full and backpressure");
    clearLogs();
    req(32'h0, 0); req(32'h4, 0); req(32'h8, 0); req(32'hC, 0);
    reqAns(32'h10, 0, 0);
    checkOutput("t3_full_fetch_ready", 96'(snap_fr), 96'(0));
    checkOutput("t3_full_mem_valid", 96'(snap_mv), 96'(0));
    reqAns(32'h10, 1, 0); reqAns(32'h10, 2, 0); reqAns(32'h10, 3, 0);
    req(32'h10, 1);
    checkOutput("t3_pop_cycle_mem_valid", 96'(snap_mv), 96'(0));
    req(32'h10, 0);
    checkOutput("t3_fifth_mem_valid", 96'(snap_mv), 96'(1));
    checkOutput("t3_fifth_tag", 96'(snap_tag), 96'(0));
    ans(0, 1);
    repeat (4) idle(1);
    checkOrder("t3", '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10});

    $display("[TB] flush with requests in flight");
    clearLogs();
    req(32'h20, 1); req(32'h24, 1); req(32'h28, 1);
    idle(1, 1);
    checkOutput("t4_model_drain", 96'(m_drain), 96'(1));
    applyStimulus(1, 32'h30, 1, 1, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, 1, 0);
    checkOutput("t4_drain_fetch_ready", 96'(snap_fr), 96'(0));
    checkOutput("t4_drain_mem_valid", 96'(snap_mv), 96'(0));
    applyStimulus(1, 32'h30, 1, 2, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, 1, 0);
    applyStimulus(1, 32'h30, 1, 3, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, 1, 0);
    checkOutput("t4_last_answer_mem_valid", 96'(snap_mv), 96'(0));
    req(32'h30, 1);
    checkOutput("t4_resume_mem_valid", 96'(snap_mv), 96'(1));
    checkOutput("t4_resume_tag", 96'(snap_tag), 96'(0));
    checkOutput("t4_no_stale_issue", 96'(issue_log.size()), 96'(0));
    ans(0, 1);
    idle(1); idle(1);
    checkOrder("t4", '{32'h30});

    $display("[TB] flush with simultaneous answer");
    clearLogs();
    idle(1, 1);
    req(32'h40, 1);
    applyStimulus(0, 32'h0, 1, 0, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, 1, 1);
    checkOutput("t5_model_drain", 96'(m_drain), 96'(0));
    req(32'h44, 1);
    checkOutput("t5_next_mem_valid", 96'(snap_mv), 96'(1));
    checkOutput("t5_next_tag", 96'(snap_tag), 96'(0));
    ans(0, 1);
    idle(1); idle(1);
    checkOrder("t5", '{32'h44});

    $display("[TB] exception forwarding and answer filter");
    clearLogs();
    req(32'h50, 1);
    applyStimulus(0, 32'h0, 1, 1, MEM_ACC_INSTR, 1, EXC_INSTR_ACCESS_FAULT, 1, 0);
    idle(1);
    checkOrder("t6a", '{32'h50});
    if (issue_log.size() == 1) begin
      checkOutput("t6a_exc", 96'(issue_log[0].exc), 96'(1));
      checkOutput("t6a_code", 96'(issue_log[0].code), 96'(1));
    end
    clearLogs();
    req(32'h54, 1);
    applyStimulus(0, 32'h0, 1, 2, MEM_ACC_LOAD, 0, EXC_INSTR_MISALIGNED, 1, 0);
    checkOutput("t6b_model_outstanding", 96'(outstanding), 96'(1));
    idle(1, 1);
    applyStimulus(1, 32'h58, 1, 2, MEM_ACC_INSTR, 0, EXC_INSTR_MISALIGNED, 1, 0);
    checkOutput("t6b_drain_mem_valid", 96'(snap_mv), 96'(0));
    req(32'h58, 1);
    checkOutput("t6b_resume_mem_valid", 96'(snap_mv), 96'(1));
    checkOutput("t6b_resume_tag", 96'(snap_tag), 96'(0));
    ans(0, 1);
    idle(1); idle(1);
    checkOrder("t6b", '{32'h58});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
